alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Execute-stage controller that drives the combinational 16-bit ALU's operand/opcode inputs and consumes its result and condition flags. It accepts decoded operations from decode over a valid/ready handshake and registers them into an issue stage that feeds the ALU. It then captures the ALU result and flags into a result stage, resolves branch conditions, and hands results to writeback over a second valid/ready handshake. The block is a 2-stage elastic pipeline with full backpressure, plus a saturating overflow event counter.

## Interface
- `DW`, 16: datapath width.
- `RW`, 3: destination register index width.
- `CW`, 8: overflow counter width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  decode has an operation.
- `in_ready`  out  1  block accepts the operation this cycle.
- `in_op`  in  4  ALU opcode.
- `in_a`, `in_b`  in  DW  operands.
- `in_rd`  in  RW  destination register.
- `alu_a`, `alu_b`  out  DW  operands to the ALU.
- `alu_op`  out  4  opcode to the ALU.
- `alu_out`  in  DW  ALU result.
- `alu_ofl`, `alu_eqz`, `alu_nez`, `alu_ltz`, `alu_gez`  in  1  ALU flags.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  writeback accepts.
- `out_result`  out  DW  result.
- `out_rd`  out  RW  destination register.
- `out_wr_en`  out  1  register write required.
- `out_br_taken`  out  1  branch condition true.
- `out_ofl`  out  1  signed overflow on ADD/SUB.
- `ofl_count`  out  CW  saturating count of retired overflowing ADD/SUB.

## Operation
- Stage I (issue) registers: `i_valid`, `i_op`, `i_a`, `i_b`, `i_rd`. It drives `alu_op = i_op` and `alu_a = i_a`.
- `alu_b`:
  - `i_b` for all ops except branches (`i_op[3:2]==2'b10`).
  - 16'h0000 for branches, so the ALU compares A against zero.
- Stage R (result) registers: `r_valid`, `r_result`, `r_rd`, `r_wr_en`, `r_br_taken`, `r_ofl`. All are captured from the ALU outputs when stage I advances.
- Capture rules:
  - `r_wr_en` = 1 unless the op is a branch (1000–1011).
  - `r_result` = `alu_out` for non-branches and 16'h0000 for branches.
  - `r_br_taken` is selected by opcode: 1000→eqz, 1001→nez, 1010→ltz, 1011→gez; 0 for non-branches.
  - `r_ofl` = `alu_ofl` only for opcodes 0000/0001; 0 otherwise.
- Handshake:
  - `r_adv = !r_valid | out_ready`
  - `i_adv = i_valid & r_adv`
  - `in_ready = !i_valid | r_adv`
- Accept: when `in_valid & in_ready`, stage I loads the new operation. Otherwise, if `i_adv`, `i_valid` clears.
- Stage R: loads when `i_adv`. Otherwise, if `out_valid & out_ready`, `r_valid` clears.
- Holding: payload registers hold while their stage is stalled. `out_*` are the stage R registers.
- `ofl_count` increments on `out_valid & out_ready & out_ofl` and saturates at all-ones; no wrap.
- Simultaneous accept and drain in the same cycle is legal; full throughput is 1 op/cycle.

## Timing
- Reset (async assert, sync-safe deassert): `i_valid`=0, `r_valid`=0, every `out_*`=0, `ofl_count`=0, `alu_a`/`alu_b`=0, `alu_op`=4'b0000. `in_ready`=1 during and after reset.
- Latency: an operation accepted in cycle N has `out_valid` in cycle N+1 registered, i.e. visible after edge N+1, when unstalled. That is 2 register stages, 1 cycle of ALU evaluation.
- Stalls:
  - While `out_valid & !out_ready`, all `out_*` stay stable.
  - If stage I is also full, `in_ready`=0.
  - No operation is dropped or duplicated.
- Reset mid-operation: both stages empty immediately; in-flight operations are discarded.
- `in_ready` depends combinationally on `out_ready`. No combinational path exists from `in_valid` to `out_*`.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (`OP_ADD`=4'b0000 … `OP_SLE`=4'b1111)
  - `is_branch(op)` function
  - `br_cond(op, eqz, nez, ltz, gez)` function
  - these are used here and by decode.
- One sub-module: `alu_issue_stage`, a single valid/ready pipeline register with a parameterised payload width, instantiated twice (I and R).
- The ALU itself is instantiated outside this block.

## Test plan
- ADD 16'h7FFF + 16'h0001, rd=3, `out_ready`=1 → 2 cycles later `out_result`=16'h8000, `out_wr_en`=1, `out_rd`=3, `out_ofl`=1; after handshake `ofl_count`=1.
- BLTZ (1010) with A=16'hFFFE, B=16'h1234 → `alu_b` observed as 0; `out_br_taken`=1, `out_wr_en`=0, `out_result`=0. BEQZ with A=0 → taken; BNEZ with A=0 → not taken.
- Backpressure: stream 4 XORs back-to-back and hold `out_ready`=0 for 5 cycles → `in_ready` drops after 2 accepts; all 4 results are delivered in order with stable payloads; none is lost.
- Throughput: 10 ops with `in_valid`=1 and `out_ready`=1 continuously → 10 results in 10 consecutive cycles after the first.
- Saturation: force 260 overflowing ADDs with `CW`=8 → `ofl_count` stops at 8'hFF.
- Reset with both stages full → `out_valid`=0 and `in_ready`=1 immediately; after release the next op returns the correct result.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcode map and condition helpers shared by decode and execute.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_BEQZ = 4'b1000;
  localparam logic [3:0] OP_BNEZ = 4'b1001;
  localparam logic [3:0] OP_BLTZ = 4'b1010;
  localparam logic [3:0] OP_BGEZ = 4'b1011;
  localparam logic [3:0] OP_SLT  = 4'b1100;
  localparam logic [3:0] OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_SEQ  = 4'b1110;
  localparam logic [3:0] OP_SLE  = 4'b1111;

  // Branches occupy the 10xx quadrant of the opcode space.
  function automatic logic is_branch(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  // Only ADD and SUB report a meaningful signed overflow.
  function automatic logic is_addsub(input logic [3:0] op);
    return op[3:1] == 3'b000;
  endfunction

  // Pick the ALU flag that decides a branch; non-branches never take.
  function automatic logic br_cond(input logic [3:0] op, input logic eqz,
                                   input logic nez, input logic ltz,
                                   input logic gez);
    logic taken;
    taken = 1'b0;
    if (is_branch(op)) begin
      case (op[1:0])
        2'b00:   taken = eqz;
        2'b01:   taken = nez;
        2'b10:   taken = ltz;
        default: taken = gez;
      endcase
    end
    return taken;
  endfunction

endpackage

// File: rtl/alu_issue_stage.sv
// One elastic pipeline register with a generic payload.
// Latency: 1 cycle from upstream accept to downstream valid.
// Backpressure: up_rdy = !dn_vld | dn_rdy, so a full stage passes stall upstream combinationally.
module alu_issue_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_dat,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_dat
);

  assign up_rdy = !dn_vld || dn_rdy;

  // Load on upstream handshake, empty on downstream handshake, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_vld <= 1'b0;
      dn_dat <= '0;
    end else if (up_vld && up_rdy) begin
      dn_vld <= 1'b1;
      dn_dat <= up_dat;
    end else if (dn_rdy) begin
      dn_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage controller: issue register feeds the ALU, result register feeds writeback.
// Latency: accept at edge N, out_valid after edge N+1; 1 op/cycle sustained.
// Backpressure: full valid/ready; in_ready depends combinationally on out_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [RW-1:0] in_rd,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_ofl,
  input  logic          alu_eqz,
  input  logic          alu_nez,
  input  logic          alu_ltz,
  input  logic          alu_gez,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RW-1:0] out_rd,
  output logic          out_wr_en,
  output logic          out_br_taken,
  output logic          out_ofl,
  output logic [CW-1:0] ofl_count
);

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] rd;
  } iss_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          wr_en;
    logic          br_taken;
    logic          ofl;
  } res_t;

  iss_t i_d, i_q;
  res_t r_d, r_q;
  logic i_valid;
  logic r_valid;
  logic r_adv;

  assign i_d = '{op: in_op, a: in_a, b: in_b, rd: in_rd};

  alu_issue_stage #(.W($bits(iss_t))) u_stage_i (
    .clk    (clk),
    .rst_n  (rst_n),
    .up_vld (in_valid),
    .up_rdy (in_ready),
    .up_dat (i_d),
    .dn_vld (i_valid),
    .dn_rdy (r_adv),
    .dn_dat (i_q)
  );

  // Branches compare A against zero, so B is forced to zero for them.
  assign alu_op = i_q.op;
  assign alu_a  = i_q.a;
  assign alu_b  = is_branch(i_q.op) ? '0 : i_q.b;

  // Turn the raw ALU outputs into the writeback record for the op in stage I.
  always_comb begin
    r_d          = '0;
    r_d.rd       = i_q.rd;
    r_d.wr_en    = !is_branch(i_q.op);
    r_d.result   = is_branch(i_q.op) ? '0 : alu_out;
    r_d.br_taken = br_cond(i_q.op, alu_eqz, alu_nez, alu_ltz, alu_gez);
    r_d.ofl      = is_addsub(i_q.op) && alu_ofl;
  end

  alu_issue_stage #(.W($bits(res_t))) u_stage_r (
    .clk    (clk),
    .rst_n  (rst_n),
    .up_vld (i_valid),
    .up_rdy (r_adv),
    .up_dat (r_d),
    .dn_vld (r_valid),
    .dn_rdy (out_ready),
    .dn_dat (r_q)
  );

  assign out_valid    = r_valid;
  assign out_result   = r_q.result;
  assign out_rd       = r_q.rd;
  assign out_wr_en    = r_q.wr_en;
  assign out_br_taken = r_q.br_taken;
  assign out_ofl      = r_q.ofl;

  // Count retired overflowing ADD/SUB, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofl_count <= '0;
    end else if (out_valid && out_ready && out_ofl && (ofl_count != {CW{1'b1}})) begin
      ofl_count <= ofl_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          wr_en;
    logic          br_taken;
    logic          ofl;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [3:0]    in_op;
  logic [DW-1:0] in_a, in_b;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] alu_a, alu_b, alu_out;
  logic [3:0]    alu_op;
  logic          alu_ofl, alu_eqz, alu_nez, alu_ltz, alu_gez;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic          out_wr_en, out_br_taken, out_ofl;
  logic [CW-1:0] ofl_count;

  int   vec  = 0;
  int   miss = 0;
  int   pops = 0;
  int   exp_cnt = 0;
  logic accepted = 1'b0;
  logic stall_prev = 1'b0;
  exp_t held;
  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .alu_ofl(alu_ofl), .alu_eqz(alu_eqz), .alu_nez(alu_nez),
    .alu_ltz(alu_ltz), .alu_gez(alu_gez),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_br_taken(out_br_taken),
    .out_ofl(out_ofl), .ofl_count(ofl_count)
  );

  function automatic logic [DW-1:0] alu_calc(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[3:0];
      4'd6:    r = a >> b[3:0];
      4'd7:    r = $signed(a) >>> b[3:0];
      4'd12:   r = {15'd0, $signed(a) < $signed(b)};
      4'd13:   r = {15'd0, a < b};
      4'd14:   r = {15'd0, a == b};
      4'd15:   r = {15'd0, $signed(a) <= $signed(b)};
      default: r = a - b;
    endcase
    return r;
  endfunction

  function automatic logic add_ofl(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] s;
    s = a + b;
    return (a[15] == b[15]) && (s[15] != a[15]);
  endfunction

  function automatic logic sub_ofl(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    d = a - b;
    return (a[15] != b[15]) && (d[15] != a[15]);
  endfunction

  // External ALU model: flags compare A with B; ofl is raised for every op, ADD-style or SUB-style.
  always_comb begin
    alu_out = alu_calc(alu_op, alu_a, alu_b);
    alu_eqz = (alu_a == alu_b);
    alu_nez = (alu_a != alu_b);
    alu_ltz = ($signed(alu_a) < $signed(alu_b));
    alu_gez = !($signed(alu_a) < $signed(alu_b));
    alu_ofl = (alu_op == 4'd0) ? add_ofl(alu_a, alu_b) : sub_ofl(alu_a, alu_b);
  end

  function automatic exp_t exp_of(input logic [3:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [RW-1:0] rd);
    exp_t e;
    e.rd = rd;
    if (op[3:2] == 2'b10) begin
      e.result = '0;
      e.wr_en  = 1'b0;
      e.ofl    = 1'b0;
      case (op[1:0])
        2'b00:   e.br_taken = (a == 16'h0000);
        2'b01:   e.br_taken = (a != 16'h0000);
        2'b10:   e.br_taken = a[15];
        default: e.br_taken = !a[15];
      endcase
    end else begin
      e.result   = alu_calc(op, a, b);
      e.wr_en    = 1'b1;
      e.br_taken = 1'b0;
      e.ofl      = (op == 4'd0) ? add_ofl(a, b) : (op == 4'd1) ? sub_ofl(a, b) : 1'b0;
    end
    return e;
  endfunction

  // One clock: scoreboard work at the negedge, return #1 after the next posedge.
  task automatic tick();
    exp_t got, e;
    @(negedge clk);
    accepted = 1'b0;
    got = {out_result, out_rd, out_wr_en, out_br_taken, out_ofl};
    if (rst_n) begin
      if (stall_prev) begin
        vec++;
        if (!out_valid || got !== held) begin
          miss++;
          $display("FAIL stall_hold: got %h vld=%b, required %h held", got, out_valid, held);
        end
      end
      if (out_valid && out_ready) begin
        vec++;
        pops++;
        if (sbq.size() == 0) begin
          miss++;
          $display("FAIL unexpected_output: got %h, required no output", got);
        end else begin
          e = sbq.pop_front();
          if (e.ofl && exp_cnt < 255) exp_cnt++;
          if (got !== e) begin
            miss++;
            $display("FAIL result: got %h, required %h", got, e);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held = got;
      if (in_valid && in_ready) begin
        sbq.push_back(exp_of(in_op, in_a, in_b, in_rd));
        accepted = 1'b1;
      end
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [RW-1:0] rd);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_rd = rd;
  endtask

  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [RW-1:0] rd);
    drive(op, a, b, rd);
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) tick();
    if (!accepted) begin
      miss++;
      $display("FAIL send_timeout: got no accept in 50 cycles, required accept");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    out_ready = 1'b0;
    #2;
    vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    vec++; if (ofl_count !== 8'h00) begin miss++; $display("FAIL rst_ofl_count: got %h, required 00", ofl_count); end
    vec++;
    if ({alu_a, alu_b, alu_op} !== 36'h0) begin
      miss++; $display("FAIL rst_alu_inputs: got %h %h %h, required 0", alu_a, alu_b, alu_op);
    end
    vec++;
    if ({out_result, out_rd, out_wr_en, out_br_taken, out_ofl} !== 22'h0) begin
      miss++; $display("FAIL rst_out_payload: got %h, required 0", out_result);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_add_ofl();
    out_ready = 1'b1;
    send(4'b0000, 16'h7FFF, 16'h0001, 3'd3);
    vec++; if (alu_b !== 16'h0001) begin miss++; $display("FAIL add_alu_b: got %h, required 0001", alu_b); end
    tick();
    vec++;
    if (out_valid !== 1'b1 || out_result !== 16'h8000 || out_ofl !== 1'b1 || out_rd !== 3'd3) begin
      miss++; $display("FAIL add_latency: got vld=%b res=%h ofl=%b rd=%0d, required 1 8000 1 3",
                       out_valid, out_result, out_ofl, out_rd);
    end
    tick();
    vec++; if (ofl_count !== 8'h01) begin miss++; $display("FAIL add_ofl_count: got %h, required 01", ofl_count); end
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    send(4'b1010, 16'hFFFE, 16'h1234, 3'd5);
    vec++;
    if (alu_b !== 16'h0000 || alu_a !== 16'hFFFE || alu_op !== 4'b1010) begin
      miss++; $display("FAIL br_alu_inputs: got a=%h b=%h op=%h, required FFFE 0000 A", alu_a, alu_b, alu_op);
    end
    send(4'b1000, 16'h0000, 16'h5555, 3'd1);
    send(4'b1001, 16'h0000, 16'h5555, 3'd2);
    send(4'b1011, 16'h8000, 16'h0001, 3'd4);
    send(4'b1001, 16'h0040, 16'h0040, 3'd6);
    drain(3);
    vec++; if (sbq.size() != 0) begin miss++; $display("FAIL br_drain: got %0d pending, required 0", sbq.size()); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(4'b0100, 16'h8000, 16'h0001, 3'd1); tick();
    drive(4'b0100, 16'h7FFF, 16'hFFFF, 3'd2); tick();
    drive(4'b0100, 16'hA5A5, 16'h5A5A, 3'd3);
    vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++; if (accepted) begin miss++; $display("FAIL bp_no_accept: got accept at stall %0d, required none", i); end
    end
    out_ready = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL bp_comb_ready: got %b, required 1", in_ready); end
    send(4'b0100, 16'hA5A5, 16'h5A5A, 3'd3);
    send(4'b0100, 16'h1234, 16'h00FF, 3'd4);
    drain(4);
    vec++; if (sbq.size() != 0) begin miss++; $display("FAIL bp_drain: got %0d pending, required 0", sbq.size()); end
    vec++; if (ofl_count !== 8'(exp_cnt)) begin miss++; $display("FAIL bp_ofl_count: got %h, required %h", ofl_count, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int first, last, cnt, p;
    first = -1; last = -1; cnt = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 14; t++) begin
      if (t < 10) drive(4'(t + 2), 16'($urandom), 16'($urandom), 3'(t));
      else in_valid = 1'b0;
      p = pops;
      tick();
      if (t < 10) begin
        vec++; if (!accepted) begin miss++; $display("FAIL b2b_accept: got stall at op %0d, required accept", t); end
      end
      if (pops > p) begin
        if (first < 0) first = t;
        last = t;
        cnt++;
      end
    end
    vec++; if (first != 2) begin miss++; $display("FAIL b2b_first: got cycle %0d, required 2", first); end
    vec++;
    if (cnt != 10 || last - first != 9) begin
      miss++; $display("FAIL b2b_rate: got %0d results over %0d cycles, required 10 over 10", cnt, last - first + 1);
    end
  endtask

  task automatic stream_add(input int n);
    out_ready = 1'b1;
    drive(4'b0000, 16'h7FFF, 16'h0001, 3'd7);
    for (int i = 0; i < n; i++) begin
      tick();
      vec++; if (!accepted) begin miss++; $display("FAIL sat_accept: got stall at op %0d, required accept", i); end
    end
    drain(3);
  endtask

  task automatic test_saturation();
    stream_add(100);
    vec++; if (ofl_count !== 8'(exp_cnt)) begin miss++; $display("FAIL sat_mid: got %h, required %h", ofl_count, exp_cnt); end
    stream_add(160);
    vec++; if (ofl_count !== 8'hFF) begin miss++; $display("FAIL sat_final: got %h, required FF", ofl_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(4'b0010, 16'hF0F0, 16'h0FF0, 3'd1);
    send(4'b0011, 16'hF000, 16'h000F, 3'd2);
    vec++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miss++; $display("FAIL mid_full: got in_ready=%b out_valid=%b, required 0 1", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ofl_count !== 8'h00) begin
      miss++; $display("FAIL mid_reset: got out_valid=%b in_ready=%b cnt=%h, required 0 1 00",
                       out_valid, in_ready, ofl_count);
    end
    sbq.delete();
    exp_cnt = 0;
    stall_prev = 1'b0;
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    send(4'b0000, 16'h1234, 16'h1111, 3'd6);
    drain(3);
    vec++; if (sbq.size() != 0 || pops == 0) begin miss++; $display("FAIL mid_recover: got %0d pending, required 0", sbq.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_ofl();
    test_branch();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
